// File: rtl/enc_pkg.sv
// Shared types and helpers for the streaming priority encoder.
// Holds the drain FSM state encoding and the code-width helper.
package enc_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_DRAIN = 1'b1
   } state_e;

   // Width of a binary index into an n-bit vector; never below one bit.
   function automatic int code_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational priority pick: selects the highest or lowest set bit of a vector,
// reports its index, and returns the vector with that bit cleared.
module prio_pick
   import enc_pkg::*;
#(
   parameter int N          = 8,
   parameter int HIGH_FIRST = 1,
   localparam int W         = code_width(N)
) (
   input  logic [N-1:0] vec_i,
   output logic [W-1:0] code_o,
   output logic         found_o,
   output logic [N-1:0] rest_o
);

   logic [N-1:0] sel;

   // Scan from lowest to highest priority so the final hit is the winner.
   function automatic int scan_idx(input int k);
      return (HIGH_FIRST != 0) ? k : (N - 1 - k);
   endfunction

   // NOTE: every output of a combinational block gets a default before any
   // conditional assignment; otherwise an untaken branch infers a latch.
   always_comb begin
      code_o = '0;
      sel    = '0;
      for (int k = 0; k < N; k++) begin
         if (vec_i[scan_idx(k)]) begin
            code_o              = W'(scan_idx(k));
            sel                 = '0;
            sel[scan_idx(k)]    = 1'b1;
         end
      end
   end

   assign found_o = |vec_i;
   assign rest_o  = vec_i & ~sel;

endmodule

// File: rtl/prio_encoder_stream.sv
// Streaming priority encoder: accepts an N-bit vector and emits one index per beat.
// Optional feature macro ENC_ZERO_PASS_EN: an all-zero vector yields one out_none beat.
module prio_encoder_stream
   import enc_pkg::*;
#(
   parameter int N          = 8,
   parameter int HIGH_FIRST = 1,
   localparam int W         = code_width(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] in_vec,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_code,
   output logic         out_last,
   output logic         out_none
);

   state_e       state_q, state_d;
   logic [N-1:0] pend_q, pend_d;
   logic [W-1:0] code_q, code_d;
   logic         last_q, last_d;
   logic         valid_q, valid_d;
`ifdef ENC_ZERO_PASS_EN
   logic         none_q, none_d;
`endif

   logic         accept;
   logic         out_hs;
   logic [N-1:0] pick_src;
   logic [W-1:0] pick_code;
   logic         pick_found;
   logic [N-1:0] pick_rest;

   // Ready may rise in the same cycle the consumer takes the final beat.
   assign in_ready = (state_q == ST_IDLE) || (valid_q && out_ready && last_q);
   assign accept   = in_valid && in_ready;
   assign out_hs   = valid_q && out_ready;

   // A single picker serves both the fresh vector and the remaining bits.
   assign pick_src = accept ? in_vec : pend_q;

   prio_pick #(
      .N          (N),
      .HIGH_FIRST (HIGH_FIRST)
   ) u_pick (
      .vec_i   (pick_src),
      .code_o  (pick_code),
      .found_o (pick_found),
      .rest_o  (pick_rest)
   );

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      code_d  = code_q;
      last_d  = last_q;
      valid_d = valid_q;
`ifdef ENC_ZERO_PASS_EN
      none_d  = none_q;
`endif
      if (accept && pick_found) begin
         code_d  = pick_code;
         pend_d  = pick_rest;
         last_d  = (pick_rest == '0);
         valid_d = 1'b1;
         state_d = ST_DRAIN;
`ifdef ENC_ZERO_PASS_EN
         none_d  = 1'b0;
      end else if (accept) begin
         code_d  = '0;
         pend_d  = '0;
         last_d  = 1'b1;
         valid_d = 1'b1;
         none_d  = 1'b1;
         state_d = ST_DRAIN;
`endif
      end else if (out_hs) begin
         if (pend_q != '0) begin
            code_d = pick_code;
            pend_d = pick_rest;
            last_d = (pick_rest == '0);
         end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values, independent of process evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         code_q  <= '0;
         last_q  <= 1'b0;
         valid_q <= 1'b0;
`ifdef ENC_ZERO_PASS_EN
         none_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         code_q  <= code_d;
         last_q  <= last_d;
         valid_q <= valid_d;
`ifdef ENC_ZERO_PASS_EN
         none_q  <= none_d;
`endif
      end
   end

   assign out_valid = valid_q;
   assign out_code  = code_q;
   assign out_last  = last_q;
`ifdef ENC_ZERO_PASS_EN
   assign out_none  = none_q;
`else
   assign out_none  = 1'b0;
`endif

endmodule

// File: tb/tb_prio_encoder_stream.sv
// Self-checking bench: a high-first and a low-first encoder share one stimulus
// stream and are compared every cycle against a queue-based reference model.
module tb_prio_encoder_stream;

   localparam int N = 8;
   localparam int W = 3;
`ifdef ENC_ZERO_PASS_EN
   localparam bit ZP = 1'b1;
`else
   localparam bit ZP = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         in_valid = 1'b0;
   logic [N-1:0] in_vec = '0;
   logic         out_ready = 1'b0;

   logic         rdy_hi, val_hi, last_hi, none_hi;
   logic [W-1:0] code_hi;
   logic         rdy_lo, val_lo, last_lo, none_lo;
   logic [W-1:0] code_lo;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   always #5 clk = ~clk;

   prio_encoder_stream #(.N(N), .HIGH_FIRST(1)) u_hi (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_hi),
      .in_vec    (in_vec),
      .out_valid (val_hi),
      .out_ready (out_ready),
      .out_code  (code_hi),
      .out_last  (last_hi),
      .out_none  (none_hi)
   );

   prio_encoder_stream #(.N(N), .HIGH_FIRST(0)) u_lo (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (rdy_lo),
      .in_vec    (in_vec),
      .out_valid (val_lo),
      .out_ready (out_ready),
      .out_code  (code_lo),
      .out_last  (last_lo),
      .out_none  (none_lo)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Reference model: the pending indices of the current vector in emission order.
   int m_q_hi[$];
   int m_q_lo[$];
   int m_code_hi = 0;
   int m_code_lo = 0;
   bit m_valid = 1'b0;
   bit m_last = 1'b0;
   bit m_none = 1'b0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid = 1'b0; m_last = 1'b0; m_none = 1'b0;
         m_code_hi = 0; m_code_lo = 0;
         m_q_hi.delete(); m_q_lo.delete();
      end else begin
         bit rdy, acc, hs;
         rdy = !m_valid || (out_ready && m_last);
         acc = in_valid && rdy;
         hs  = m_valid && out_ready;
         if (acc && in_vec != '0) begin
            m_q_hi.delete(); m_q_lo.delete();
            for (int i = N - 1; i >= 0; i--) if (in_vec[i]) m_q_hi.push_back(i);
            for (int i = 0; i < N; i++)      if (in_vec[i]) m_q_lo.push_back(i);
            m_code_hi = m_q_hi.pop_front();
            m_code_lo = m_q_lo.pop_front();
            m_last = (m_q_hi.size() == 0);
            m_none = 1'b0;
            m_valid = 1'b1;
         end else if (acc && ZP) begin
            m_code_hi = 0; m_code_lo = 0;
            m_last = 1'b1; m_none = 1'b1; m_valid = 1'b1;
         end else if (hs) begin
            if (m_q_hi.size() != 0) begin
               m_code_hi = m_q_hi.pop_front();
               m_code_lo = m_q_lo.pop_front();
               m_last = (m_q_hi.size() == 0);
            end else begin
               m_valid = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         bit m_ready;
         m_ready = !m_valid || (out_ready && m_last);
         check("hi_in_ready",  32'(rdy_hi),  32'(m_ready));
         check("lo_in_ready",  32'(rdy_lo),  32'(m_ready));
         check("hi_out_valid", 32'(val_hi),  32'(m_valid));
         check("lo_out_valid", 32'(val_lo),  32'(m_valid));
         check("hi_out_code",  32'(code_hi), 32'(m_code_hi));
         check("lo_out_code",  32'(code_lo), 32'(m_code_lo));
         if (m_valid) begin
            check("hi_out_last", 32'(last_hi), 32'(m_last));
            check("lo_out_last", 32'(last_lo), 32'(m_last));
            check("hi_out_none", 32'(none_hi), 32'(m_none));
            check("lo_out_none", 32'(none_lo), 32'(m_none));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input string tag, input int exp_hi, input int exp_lo,
                       input bit exp_last, input bit exp_rdy);
      @(negedge clk);
      check({tag, "_valid"}, 32'(val_hi && val_lo), 32'd1);
      check({tag, "_hi"},    32'(code_hi), 32'(exp_hi));
      check({tag, "_lo"},    32'(code_lo), 32'(exp_lo));
      check({tag, "_last"},  32'(last_hi), 32'(exp_last));
      check({tag, "_rdy"},   32'(rdy_hi),  32'(exp_rdy));
   endtask

   initial begin
      // Reset held while a full vector is offered.
      #1 rst_n = 1'b0;
      in_valid = 1'b1; in_vec = 8'hFF; out_ready = 1'b1;
      #1 cmp_en = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("rst_valid", 32'(val_hi), 32'd0);
      check("rst_code",  32'(code_hi), 32'd0);
      check("rst_ready", 32'(rdy_hi), 32'd1);
      tick();
      in_valid = 1'b0;
      rst_n = 1'b1;
      repeat (3) tick();
      @(negedge clk);
      check("post_rst_idle", 32'(val_hi || val_lo), 32'd0);

      // Drain order with the consumer always ready.
      tick();
      in_valid = 1'b1; in_vec = 8'b1010_0100;
      tick();
      in_valid = 1'b0; in_vec = 8'h00;
      beat("drain1", 7, 2, 1'b0, 1'b0);
      beat("drain2", 5, 5, 1'b0, 1'b0);
      beat("drain3", 2, 7, 1'b1, 1'b1);
      tick();
      @(negedge clk);
      check("drain_idle", 32'(val_hi), 32'd0);
      check("drain_hold", 32'(code_hi), 32'd2);

      // Backpressure on the first beat; later vector changes must be ignored.
      tick();
      out_ready = 1'b0;
      in_valid = 1'b1; in_vec = 8'b1010_0100;
      tick();
      in_valid = 1'b0; in_vec = 8'hFF;
      beat("bp_a", 7, 2, 1'b0, 1'b0);
      tick();
      beat("bp_b", 7, 2, 1'b0, 1'b0);
      tick();
      beat("bp_c", 7, 2, 1'b0, 1'b0);
      tick();
      out_ready = 1'b1;
      beat("bp_d", 7, 2, 1'b0, 1'b0);
      beat("bp_e", 5, 5, 1'b0, 1'b0);
      beat("bp_f", 2, 7, 1'b1, 1'b1);
      tick();

      // Two set bits at the extremes exercise both priority directions.
      in_valid = 1'b1; in_vec = 8'h81;
      tick();
      in_valid = 1'b0;
      beat("ends1", 7, 0, 1'b0, 1'b0);
      beat("ends2", 0, 7, 1'b1, 1'b1);
      tick();

      // Back-to-back: next vector accepted on the last-beat handshake.
      in_valid = 1'b1; in_vec = 8'h01;
      tick();
      in_vec = 8'h80;
      beat("b2b1", 0, 0, 1'b1, 1'b1);
      tick();
      in_valid = 1'b0;
      beat("b2b2", 7, 7, 1'b1, 1'b1);
      tick();

      // All-zero vector.
      in_valid = 1'b1; in_vec = 8'h00;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
`ifdef ENC_ZERO_PASS_EN
      check("zero_valid", 32'(val_hi), 32'd1);
      check("zero_code",  32'(code_hi), 32'd0);
      check("zero_none",  32'(none_hi), 32'd1);
      check("zero_last",  32'(last_hi), 32'd1);
`else
      check("zero_valid", 32'(val_hi), 32'd0);
      check("zero_ready", 32'(rdy_hi), 32'd1);
      check("zero_none",  32'(none_hi), 32'd0);
`endif
      tick();

      // Reset in the middle of a drain.
      in_valid = 1'b1; in_vec = 8'hFF;
      tick();
      in_valid = 1'b0;
      beat("mid1", 7, 0, 1'b0, 1'b0);
      beat("mid2", 6, 1, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1 check("mid_rst_valid", 32'(val_hi || val_lo), 32'd0);
      tick();
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("mid_no_resume", 32'(val_hi || val_lo), 32'd0);
      end
      tick();

      // Randomized traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 599) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
         in_valid  = ($urandom_range(0, 2) != 0);
         in_vec    = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         tick();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (12) tick();
      @(negedge clk);
      cmp_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_encoder_stream.md
# prio_encoder_stream

Parametrised, registered successor to the fixed 4-to-2 encoder. It accepts an N-bit request vector through a valid/ready handshake. It then emits the binary index of every set bit, one per output beat, in a configurable priority order. It sits between request-collecting logic (interrupt lines, grant vectors) and a downstream consumer that handles one index at a time.

## Interface
- N, default 8: request vector width; N ≥ 2.
- HIGH_FIRST, default 1: 1 emits the highest set index first; 0 emits the lowest first.
- W (localparam) = $clog2(N): code width.
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: in_vec is valid.
- in_ready, output, 1: block can accept a vector this cycle.
- in_vec, input, N: request vector.
- out_valid, output, 1: out_code is valid.
- out_ready, input, 1: consumer takes the beat this cycle.
- out_code, output, W: index of the current set bit.
- out_last, output, 1: final beat of the current vector.
- out_none, output, 1: zero-vector beat. Driven 0 unless ENC_ZERO_PASS_EN is defined.

## Operation
- States: ST_IDLE (no pending bits) and ST_DRAIN (beat held on outputs).
- Accept occurs when in_valid && in_ready.
- in_ready is 1 in ST_IDLE. In ST_DRAIN it is 1 only when out_valid && out_ready && out_last in the same cycle. This is a combinational path from out_ready to in_ready.
- Accept of a non-zero vector v:
  - out_code = priority pick of v.
  - pend = v with the picked bit cleared.
  - out_last = (pend == 0).
  - out_valid = 1; go to ST_DRAIN.
- Output handshake with pend ≠ 0:
  - Load the next pick from pend and clear that bit.
  - Update out_last the same way.
- Output handshake with pend == 0 and no simultaneous accept: out_valid = 0, state goes to ST_IDLE. out_code holds its last value.
- Output handshake with a simultaneous accept: the new vector is loaded and there is no bubble.
- While out_valid && !out_ready, out_code, out_last and out_none are held stable.
- in_vec is sampled only on accept. Later changes are ignored.

## Timing
- Reset values:
  - out_valid = 0, out_code = 0, out_last = 0, out_none = 0.
  - pend = 0, state = ST_IDLE, so in_ready = 1.
- Asserting rst_n mid-drain discards all pending bits immediately. The first accept after release behaves as from reset.
- Latency: accept at edge k → out_valid = 1 from edge k onward, i.e. visible in cycle k+1.
- Throughput: a vector with popcount p occupies p beats. The next vector may be accepted on the last-beat handshake cycle.
- All outputs are registered except in_ready.

## Configuration
- ENC_ZERO_PASS_EN defined: an accepted all-zero vector produces one beat with out_code = 0, out_none = 1, out_last = 1.
- ENC_ZERO_PASS_EN undefined: an all-zero vector is accepted, in_ready stays 1, no beat is produced, and state is unchanged. out_none is tied 0.

## Structure
- Package enc_pkg holds the state enum (ST_IDLE, ST_DRAIN) and a width helper for W.
- Sub-module prio_pick is combinational.
  - Parameters: N, HIGH_FIRST.
  - Input: vector.
  - Outputs: code, found, and the vector with the picked bit cleared.
- prio_pick is instantiated once and muxed between in_vec (on accept) and pend (on drain).

## Test plan
All scenarios use N=8.
- **Reset:** hold rst_n=0, drive in_valid=1 with in_vec=8'hFF → out_valid=0, out_code=0, in_ready=1. No beat after release until a new accept.
- **Drain order:** HIGH_FIRST=1, in_vec=8'b1010_0100, out_ready=1 → codes 7, 5, 2 on consecutive cycles. out_last=1 only on 2. in_ready=0 during codes 7 and 5.
- **Backpressure:** same vector, out_ready=0 for 3 cycles on the first beat → out_code stays 7, out_last=0, pend unchanged. Then 5 and 2 follow.
- **Low priority:** HIGH_FIRST=0, in_vec=8'h81 → code 0, then code 7 with out_last=1.
- **Back-to-back / zero vector:**
  - 8'h01, then 8'h80 presented while code 0 is the last beat → code 7 the next cycle with no bubble.
  - 8'h00 with ENC_ZERO_PASS_EN → one beat: code 0, none=1, last=1.
  - 8'h00 without ENC_ZERO_PASS_EN → no beat.
- **Reset mid-drain:** 8'hFF accepted, rst_n pulsed low after two beats → out_valid=0 at once and the remaining bits are never emitted.
